// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared UART frame control constants, state codes and checksum helper
package uart_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LEN     = 3'd1;
  localparam state_t ST_PAYLOAD = 3'd2;
  localparam state_t ST_CHECK   = 3'd3;
  localparam state_t ST_HOLD    = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Running frame checksum: XOR of LEN and every payload byte
  function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload RAM with one write port and one registered read port
module uart_frame_buf
  import uart_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Storage and read register carry no reset; read data holds while rd_en is low
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - turns the UART_RX byte stream into checked, held command frames
module uart_rx_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int         MAX_PAYLOAD  = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 5000,
  parameter int         AW           = $clog2(MAX_PAYLOAD)
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  input  logic [AW-1:0] i_Rd_Addr,
  input  logic          i_Rd_En,
  output logic [7:0]    o_Rd_Data,
  input  logic          i_Frame_Ack,
  output logic          o_Frame_Valid,
  output logic [AW:0]   o_Frame_Len,
  output logic          o_Err_Chk,
  output logic          o_Err_Len,
  output logic          o_Err_Timeout,
  output logic [7:0]    o_Drop_Count,
  output logic [2:0]    o_State
);

  localparam int            TW      = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);

  state_t        state;
  logic          dv_q;
  logic          strobe;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx;
  logic [7:0]    chk;
  logic [TW-1:0] to_cnt;
  logic [7:0]    drop_cnt;
  logic          rd_seen;
  logic [7:0]    buf_rd_data;

  // DV is a level; only its rising edge counts as a byte
  assign strobe = i_RX_DV & ~dv_q;

  assign o_State       = state;
  assign o_Frame_Valid = (state == ST_HOLD);
  assign o_Frame_Len   = (state == ST_HOLD) ? len_q : '0;
  assign o_Drop_Count  = drop_cnt;
  assign o_Rd_Data     = rd_seen ? buf_rd_data : 8'h00;

  uart_frame_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .i_Clock (i_Clock),
    .wr_en   (strobe && (state == ST_PAYLOAD)),
    .wr_addr (idx),
    .wr_data (i_RX_Byte),
    .rd_en   (i_Rd_En),
    .rd_addr (i_Rd_Addr),
    .rd_data (buf_rd_data)
  );

  // Registered copy of DV for rising-edge detection
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) dv_q <= 1'b0;
    else            dv_q <= i_RX_DV;
  end

  // Frame FSM with checksum, length capture and inter-byte timeout
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      idx           <= '0;
      chk           <= 8'h00;
      to_cnt        <= '0;
      o_Err_Chk     <= 1'b0;
      o_Err_Len     <= 1'b0;
      o_Err_Timeout <= 1'b0;
    end else begin
      o_Err_Chk     <= 1'b0;
      o_Err_Len     <= 1'b0;
      o_Err_Timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (strobe && (i_RX_Byte == SYNC_BYTE)) state <= ST_LEN;
        end
        ST_LEN, ST_PAYLOAD, ST_CHECK: begin
          if (strobe) begin
            to_cnt <= '0;
            if (state == ST_LEN) begin
              if ((i_RX_Byte == 8'h00) || (i_RX_Byte > MAX_LEN)) begin
                o_Err_Len <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                len_q <= i_RX_Byte[AW:0];
                chk   <= i_RX_Byte;
                idx   <= '0;
                state <= ST_PAYLOAD;
              end
            end else if (state == ST_PAYLOAD) begin
              chk <= chk_next(chk, i_RX_Byte);
              idx <= idx + 1'b1;
              if ({1'b0, idx} == (len_q - 1'b1)) state <= ST_CHECK;
            end else begin
              if (i_RX_Byte == chk) begin
                state <= ST_HOLD;
              end else begin
                o_Err_Chk <= 1'b1;
                state     <= ST_IDLE;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            o_Err_Timeout <= 1'b1;
            to_cnt        <= '0;
            state         <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          to_cnt <= '0;
          if (i_Frame_Ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bytes arriving while a frame is held are discarded and counted, saturating
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n)                                          drop_cnt <= 8'h00;
    else if (strobe && (state == ST_HOLD) && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
  end

  // Read data reads as 0 after reset until the first read request
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n)   rd_seen <= 1'b0;
    else if (i_Rd_En) rd_seen <= 1'b1;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  import uart_ctrl_pkg::*;

  localparam int MAXP = 16;
  localparam int TO   = 5000;
  localparam int AW   = 4;
  localparam int K_OK = 0, K_CHK = 1, K_LEN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic          ack = 1'b0;
  logic [7:0]    rd_data;
  logic          valid;
  logic [AW:0]   flen;
  logic          e_chk, e_len, e_to;
  logic [7:0]    drop;
  logic [2:0]    st;

  int n_checks = 0;
  int n_errors = 0;
  int n_chk_p = 0, n_len_p = 0, n_to_p = 0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .MAX_PAYLOAD  (MAXP),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .i_Rd_Addr     (rd_addr),
    .i_Rd_En       (rd_en),
    .o_Rd_Data     (rd_data),
    .i_Frame_Ack   (ack),
    .o_Frame_Valid (valid),
    .o_Frame_Len   (flen),
    .o_Err_Chk     (e_chk),
    .o_Err_Len     (e_len),
    .o_Err_Timeout (e_to),
    .o_Drop_Count  (drop),
    .o_State       (st)
  );

  always @(negedge clk) begin
    if (e_chk) n_chk_p++;
    if (e_len) n_len_p++;
    if (e_to)  n_to_p++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_byte = b;
    rx_dv   = 1'b1;
    repeat (hold) @(negedge clk);
    rx_dv = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string name, input int a, input logic [7:0] exp);
    rd_addr = a[AW-1:0];
    rd_en   = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check($sformatf("%s rd[%0d]", name, a), rd_data, exp);
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({name, " valid after ack"}, valid, 1'b0);
    check({name, " state after ack"}, st, ST_IDLE);
  endtask

  task automatic run_frame(input string name, input logic [7:0] seq[$], input int hold,
                           input int kind, input int exp_len, input logic [7:0] pl[$]);
    int c0, l0, t0;
    c0 = n_chk_p; l0 = n_len_p; t0 = n_to_p;
    foreach (seq[i]) send_byte(seq[i], hold);
    repeat (2) @(negedge clk);
    check({name, " chk pulses"}, n_chk_p - c0, (kind == K_CHK) ? 1 : 0);
    check({name, " len pulses"}, n_len_p - l0, (kind == K_LEN) ? 1 : 0);
    check({name, " timeout pulses"}, n_to_p - t0, 0);
    check({name, " valid"}, valid, (kind == K_OK));
    if (kind == K_OK) begin
      check({name, " len"}, flen, exp_len);
      check({name, " state hold"}, st, ST_HOLD);
      for (int a = 0; a < exp_len; a++) read_check(name, a, pl[a]);
      do_ack(name);
    end else begin
      check({name, " state idle"}, st, ST_IDLE);
    end
  endtask

  // Frame-level reference: locate SYNC, apply the length rule, XOR LEN and payload
  task automatic predict(input logic [7:0] seq[$], output int kind, output int len,
                         output logic [7:0] pl[$]);
    int s;
    logic [7:0] x;
    s = 0;
    while (seq[s] != 8'hA5) s++;
    len = int'(seq[s+1]);
    pl.delete();
    if (len == 0 || len > MAXP) begin
      kind = K_LEN;
    end else begin
      x = seq[s+1];
      for (int i = 0; i < len; i++) begin
        pl.push_back(seq[s+2+i]);
        x = x ^ seq[s+2+i];
      end
      kind = (seq[s+2+len] == x) ? K_OK : K_CHK;
    end
  endtask

  typedef struct {
    logic [7:0] data [0:19];
    int         n;
    int         hold;
    int         pl_off;
    int         kind;
    int         exp_len;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [7:0] seq[$];
    logic [7:0] pl[$];
    logic [7:0] x;
    int kind, len, elapsed, c0, l0, t0, njunk;

    // ---- vector table ----
    tbl[0].data[0:5] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    tbl[0].n = 6; tbl[0].hold = 501; tbl[0].pl_off = 2; tbl[0].kind = K_OK;  tbl[0].exp_len = 3;
    tbl[1].data[0:4] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    tbl[1].n = 5; tbl[1].hold = 2;   tbl[1].pl_off = 2; tbl[1].kind = K_CHK; tbl[1].exp_len = 0;
    tbl[2].data[0:4] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    tbl[2].n = 5; tbl[2].hold = 1;   tbl[2].pl_off = 2; tbl[2].kind = K_OK;  tbl[2].exp_len = 2;
    tbl[3].data[0:1] = '{8'hA5, 8'h00};
    tbl[3].n = 2; tbl[3].hold = 1;   tbl[3].pl_off = 2; tbl[3].kind = K_LEN; tbl[3].exp_len = 0;
    tbl[4].data[0:1] = '{8'hA5, 8'h11};
    tbl[4].n = 2; tbl[4].hold = 3;   tbl[4].pl_off = 2; tbl[4].kind = K_LEN; tbl[4].exp_len = 0;
    tbl[5].data[0] = 8'hA5;
    tbl[5].data[1] = 8'h10;
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      tbl[5].data[2+i] = 8'(i * 7 + 1);
      x = x ^ 8'(i * 7 + 1);
    end
    tbl[5].data[18] = x;
    tbl[5].n = 19; tbl[5].hold = 1; tbl[5].pl_off = 2; tbl[5].kind = K_OK; tbl[5].exp_len = 16;
    tbl[6].data[0:6] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    tbl[6].n = 7; tbl[6].hold = 2;   tbl[6].pl_off = 5; tbl[6].kind = K_OK;  tbl[6].exp_len = 1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset valid", valid, 1'b0);
    check("reset len", flen, 0);
    check("reset state", st, ST_IDLE);
    check("reset drop", drop, 8'h00);
    check("reset rd_data", rd_data, 8'h00);
    check("reset errs", {e_chk, e_len, e_to}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table-driven frames ----
    for (int v = 0; v < 7; v++) begin
      seq.delete();
      pl.delete();
      for (int j = 0; j < tbl[v].n; j++) seq.push_back(tbl[v].data[j]);
      for (int j = 0; j < tbl[v].exp_len; j++) pl.push_back(tbl[v].data[tbl[v].pl_off + j]);
      run_frame($sformatf("vec%0d", v), seq, tbl[v].hold, tbl[v].kind, tbl[v].exp_len, pl);
    end

    // read data holds while rd_en is low
    seq = '{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h02 ^ 8'hC1 ^ 8'hC2};
    foreach (seq[i]) send_byte(seq[i], 1);
    read_check("hold", 1, 8'hC2);
    rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    check("rd_data holds", rd_data, 8'hC2);
    do_ack("hold");

    // ---- timeout exactly TO clocks after the last strobe ----
    t0 = n_to_p;
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    elapsed = 1;
    while (elapsed < TO + 10 && !e_to) begin
      @(negedge clk);
      elapsed++;
    end
    check("timeout latency", elapsed, TO);
    @(negedge clk);
    check("timeout pulse count", n_to_p - t0, 1);
    check("timeout state", st, ST_IDLE);

    // ---- strobe on the timeout cycle wins ----
    t0 = n_to_p;
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h22, 1);
    repeat (3) @(negedge clk);
    check("no timeout on strobe", n_to_p - t0, 0);
    check("still payload", st, ST_PAYLOAD);
    seq = '{8'h33, 8'h03};
    pl  = '{8'h11, 8'h22, 8'h33};
    run_frame("late strobe", seq, 1, K_OK, 3, pl);

    // ---- drops while held, including one in the ack cycle ----
    check("drop before", drop, 8'h00);
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    foreach (seq[i]) send_byte(seq[i], 1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 2);
    rx_byte = 8'hA5; rx_dv = 1'b1; ack = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; ack = 1'b0;
    @(negedge clk);
    check("drop 3", drop, 8'd3);
    check("ack-cycle byte not parsed", st, ST_IDLE);
    check("valid after drop ack", valid, 1'b0);
    foreach (seq[i]) send_byte(seq[i], 1);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1);
    check("drop saturates", drop, 8'd255);
    check("valid during drops", valid, 1'b1);
    do_ack("drops");

    // ---- reset mid-payload ----
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    foreach (seq[i]) send_byte(seq[i], 1);
    check("mid payload state", st, ST_PAYLOAD);
    c0 = n_chk_p; l0 = n_len_p; t0 = n_to_p;
    rst_n = 1'b0;
    #1;
    check("async reset state", st, ST_IDLE);
    check("async reset valid", valid, 1'b0);
    check("async reset drop", drop, 8'h00);
    check("async reset rd_data", rd_data, 8'h00);
    check("async reset len", flen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset no err pulses", (n_chk_p - c0) + (n_len_p - l0) + (n_to_p - t0), 0);
    seq = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h02 ^ 8'hAB ^ 8'hCD};
    pl  = '{8'hAB, 8'hCD};
    run_frame("after reset", seq, 1, K_OK, 2, pl);

    // ---- randomized frames against the reference ----
    for (int f = 0; f < 40; f++) begin
      int r, hold;
      logic [7:0] b, lb;
      seq.delete();
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        seq.push_back(b);
      end
      seq.push_back(8'hA5);
      r = $urandom_range(0, 9);
      if (r == 0)      lb = 8'h00;
      else if (r == 1) lb = 8'($urandom_range(MAXP + 1, 255));
      else             lb = 8'($urandom_range(1, MAXP));
      seq.push_back(lb);
      if (lb != 0 && int'(lb) <= MAXP) begin
        x = lb;
        for (int j = 0; j < int'(lb); j++) begin
          b = 8'($urandom);
          seq.push_back(b);
          x = x ^ b;
        end
        seq.push_back(($urandom_range(0, 1) == 0) ? x : 8'($urandom));
      end
      predict(seq, kind, len, pl);
      hold = $urandom_range(1, 3);
      run_frame($sformatf("rand%0d", f), seq, hold, kind, (kind == K_OK) ? len : 0, pl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
